dcache_responder: RTL and testbench
===================================

// Module: dcache_responder
// PURPOSE
//  Memory-side responder for the core's data-cache port: serves dcache_addr/re/we/din, returns
//  dcache_dout and drives stall. Direct-mapped, one 32-bit word per line, write-through with
//  write-update on hit, no write-allocate. Misses and all writes go to a ready/valid backing memory.
// PARAMETERS
//  LINES  64  number of cache lines; power of 2, >=2; IDX=log2(LINES), TAG=30-IDX bits
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   asynchronous, active-low reset
//  dcache_addr     in   32  byte address; [1:0] ignored, index=[IDX+1:2], tag=[31:IDX+2]
//  dcache_re       in   1   read request
//  dcache_we       in   4   byte-lane write enables; nonzero = write (takes precedence over re)
//  dcache_din      in   32  write data, lane-aligned
//  dcache_dout     out  32  read data, registered
//  stall           out  1   combinational; core holds addr/re/we/din stable while high
//  mem_req_valid   out  1   backing-memory request valid
//  mem_req_ready   in   1   backing memory accepts request when valid&&ready
//  mem_req_rw      out  1   1=write, 0=read
//  mem_req_addr    out  32  word-aligned address ({dcache_addr[31:2],2'b00})
//  mem_req_data    out  32  write data (dcache_din)
//  mem_req_mask    out  4   write byte mask (dcache_we); 0 for reads
//  mem_resp_valid  in   1   read data valid (one pulse per read request)
//  mem_resp_data   in   32  read data
// BEHAVIOUR
//  States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
//  Reset (reset==0, async): state=IDLE, all valid bits=0, dcache_dout=0, mem_req_valid=0.
//   Reset mid-transaction abandons it; any later mem_resp_valid outside RD_WAIT is ignored.
//  hit = valid[idx] && tag[idx]==addr tag.
//  stall = (state in RD_REQ,RD_WAIT,WR_REQ) || (state==IDLE && (we!=0 || (re && !hit))).
//   stall is 0 in DONE and on an IDLE read hit / no request.
//  IDLE:
//   we!=0          -> WR_REQ.
//   re && hit      -> dcache_dout <= line data at this edge (1-cycle read latency), stay IDLE.
//   re && !hit     -> RD_REQ.
//   none           -> stay IDLE; dcache_dout holds.
//  RD_REQ: mem_req_valid=1, rw=0, mask=0. On ready -> RD_WAIT.
//  RD_WAIT: mem_req_valid=0. On mem_resp_valid: line data<=mem_resp_data, tag written, valid=1;
//   -> IDLE. The held request then hits next cycle: stall=0, dout updated at that edge.
//  WR_REQ: mem_req_valid=1, rw=1, data=din, mask=we. On ready: if hit, merge din into line per
//   we lanes (misses do not allocate); -> DONE.
//  DONE: stall=0 for exactly one cycle so the core retires the write; -> IDLE unconditionally.
//  mem_req_* stable while valid && !ready; mem_req_valid is never dropped before ready.
//  Request and response in the same cycle impossible (RD_WAIT entered only after acceptance).
//  re and we both set: treated as write; no read data returned.
//  dcache_dout changes only on an IDLE read hit edge; otherwise holds its value.
// TESTING
//  1 Reset, re=1 addr=0x100 -> stall=1, mem read addr 0x100; resp 0xDEADBEEF -> next cycle
//    stall=0, dout=0xDEADBEEF the following cycle; valid[idx]=1.
//  2 Repeat read 0x100 -> stall stays 0, dout=0xDEADBEEF one cycle later, no mem request.
//  3 Write 0x100 we=4'b0011 din=0x0000CAFE, ready after 3 cycles -> mask=0011, stall high
//    until DONE cycle; read 0x100 then hits with dout=0xDEADCAFE.
//  4 Write miss 0x200 -> mem write issued, no allocate; read 0x200 -> misses, goes to memory.
//  5 Conflict: read 0x100 then 0x100+4*LINES -> second misses and evicts; 0x100 misses again.
//  6 Assert reset during RD_WAIT -> mem_req_valid=0, dout=0 immediately; late mem_resp_valid
//    ignored; next read of same address misses.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through data-cache responder.
// Read misses and all writes are forwarded to a ready/valid backing memory.
module dcache_responder #(
    parameter int unsigned LINES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int unsigned IDX = $clog2(LINES);
    localparam int unsigned TAG = 30 - IDX;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]     state_q;
    logic [2:0]     state_d;
    logic [31:0]    data_q [0:LINES-1];
    logic [TAG-1:0] tag_q  [0:LINES-1];
    logic [LINES-1:0] valid_q;

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic           hit;
    logic           is_write;
    logic           fill;
    logic           wr_done;
    logic           unused_addr_lsb;

    assign idx             = dcache_addr[IDX+1:2];
    assign tag             = dcache_addr[31:IDX+2];
    assign hit             = valid_q[idx] && (tag_q[idx] == tag);
    assign is_write        = (dcache_we != 4'b0000);
    assign fill            = (state_q == S_RD_WAIT) && mem_resp_valid;
    assign wr_done         = (state_q == S_WR_REQ) && mem_req_ready;
    assign unused_addr_lsb = ^dcache_addr[1:0];

    // Request fields come straight from the held core request; valid/rw/mask decode the state.
    assign mem_req_valid = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign mem_req_rw    = (state_q == S_WR_REQ);
    assign mem_req_addr  = {dcache_addr[31:2], 2'b00};
    assign mem_req_data  = dcache_din;
    assign mem_req_mask  = (state_q == S_WR_REQ) ? dcache_we : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_write) begin
                    state_d = S_WR_REQ;
                    stall   = 1'b1;
                end else if (dcache_re && !hit) begin
                    state_d = S_RD_REQ;
                    stall   = 1'b1;
                end
            end
            S_RD_REQ: begin
                stall = 1'b1;
                if (mem_req_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) state_d = S_IDLE;
            end
            S_WR_REQ: begin
                stall = 1'b1;
                if (mem_req_ready) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data only moves on an idle read hit; writes never return data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcache_dout <= 32'h0;
        end else if ((state_q == S_IDLE) && !is_write && dcache_re && hit) begin
            dcache_dout <= data_q[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[idx] <= mem_resp_data;
            tag_q[idx]  <= tag;
        end else if (wr_done && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (dcache_we[b]) data_q[idx][8*b +: 8] <= dcache_din[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed self-checking bench for dcache_responder; the bench plays the backing memory.
module tb_dcache_responder;

    localparam int unsigned LINES = 64;

    logic        clk;
    logic        reset;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_checks = 0;
    int n_errors = 0;

    dcache_responder #(.LINES(LINES)) dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read-miss transaction starting from IDLE; memory answers with rdata.
    task automatic read_miss(input logic [31:0] a, input logic [31:0] rdata);
        dcache_addr = a;
        dcache_re   = 1'b1;
        dcache_we   = 4'b0000;
        #1;
        check("rm_idle_stall", 32'(stall), 32'd1);
        tick();
        check("rm_req_valid", 32'(mem_req_valid), 32'd1);
        check("rm_req_rw", 32'(mem_req_rw), 32'd0);
        check("rm_req_addr", mem_req_addr, {a[31:2], 2'b00});
        check("rm_req_mask", 32'(mem_req_mask), 32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("rm_wait_valid", 32'(mem_req_valid), 32'd0);
        check("rm_wait_stall", 32'(stall), 32'd1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        #1;
        check("rm_refill_stall", 32'(stall), 32'd0);
        tick();
        check("rm_dout", dcache_dout, rdata);
        dcache_re = 1'b0;
    endtask

    // Write from IDLE, ready withheld for `delay` cycles; dout must keep exp_dout throughout.
    task automatic write_op(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                            input int delay, input logic with_re, input logic [31:0] exp_dout);
        dcache_addr = a;
        dcache_we   = we;
        dcache_din  = din;
        dcache_re   = with_re;
        #1;
        check("wr_idle_stall", 32'(stall), 32'd1);
        tick();
        check("wr_req_valid", 32'(mem_req_valid), 32'd1);
        check("wr_req_rw", 32'(mem_req_rw), 32'd1);
        check("wr_req_addr", mem_req_addr, {a[31:2], 2'b00});
        check("wr_req_data", mem_req_data, din);
        check("wr_req_mask", 32'(mem_req_mask), 32'(we));
        for (int i = 0; i < delay; i++) begin
            tick();
            check("wr_hold_valid", 32'(mem_req_valid), 32'd1);
            check("wr_hold_stall", 32'(stall), 32'd1);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("wr_done_stall", 32'(stall), 32'd0);
        check("wr_done_valid", 32'(mem_req_valid), 32'd0);
        dcache_we = 4'b0000;
        dcache_re = 1'b0;
        tick();
        check("wr_dout_hold", dcache_dout, exp_dout);
    endtask

    task automatic read_hit(input logic [31:0] a, input logic [31:0] exp);
        dcache_addr = a;
        dcache_re   = 1'b1;
        dcache_we   = 4'b0000;
        #1;
        check("rh_stall", 32'(stall), 32'd0);
        check("rh_no_req", 32'(mem_req_valid), 32'd0);
        tick();
        check("rh_dout", dcache_dout, exp);
        dcache_re = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        dcache_addr    = 32'h0;
        dcache_re      = 1'b0;
        dcache_we      = 4'b0000;
        dcache_din     = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        tick();
        tick();
        check("rst_dout", dcache_dout, 32'h0);
        check("rst_valid", 32'(mem_req_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        tick();

        // 1: cold miss fills the line
        read_miss(32'h100, 32'hDEADBEEF);
        // 2: repeat read hits with no memory traffic
        read_hit(32'h100, 32'hDEADBEEF);
        read_hit(32'h100, 32'hDEADBEEF);
        // 3: partial write hit merges lanes
        write_op(32'h100, 4'b0011, 32'h0000CAFE, 3, 1'b0, 32'hDEADBEEF);
        read_hit(32'h100, 32'hDEADCAFE);
        // 4: write miss (re also set: write wins) does not allocate
        write_op(32'h200, 4'b1111, 32'h12345678, 0, 1'b1, 32'hDEADCAFE);
        read_miss(32'h200, 32'h12345678);
        // 5: conflicting addresses evict each other
        read_miss(32'h100, 32'hDEADCAFE);
        read_miss(32'h100 + 4 * LINES, 32'h12345678);
        read_miss(32'h100, 32'hDEADCAFE);
        read_hit(32'h100, 32'hDEADCAFE);

        // 6: reset during RD_WAIT abandons the read
        dcache_addr = 32'h300;
        dcache_re   = 1'b1;
        tick();
        check("r6_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("r6_rst_valid", 32'(mem_req_valid), 32'd0);
        check("r6_rst_dout", dcache_dout, 32'h0);
        dcache_re = 1'b0;
        tick();
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0BAD0;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        check("r6_late_dout", dcache_dout, 32'h0);
        check("r6_late_valid", 32'(mem_req_valid), 32'd0);
        read_miss(32'h300, 32'h0BADF00D);
        read_miss(32'h100, 32'hDEADCAFE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
